// File: rtl/ven_dispense_ctrl_if.sv
// Coin / dispense / change handshake bundle for ven_dispense_ctrl.
//   master : the environment side (coin acceptor, user panel, dispenser, change unit)
//   slave  : the controller side
// Inputs to the controller : coin_valid, coin_type[1:0], cancel, disp_ack, chg_ack
// Outputs of the controller: coin_ready, coin_reject, disp_req, chg_req, credit[3:0], busy
interface ven_dispense_ctrl_if;
  logic       coin_valid;
  logic [1:0] coin_type;
  logic       cancel;
  logic       disp_ack;
  logic       chg_ack;
  logic       coin_ready;
  logic       coin_reject;
  logic       disp_req;
  logic       chg_req;
  logic [3:0] credit;
  logic       busy;

  modport master (
    output coin_valid, coin_type, cancel, disp_ack, chg_ack,
    input  coin_ready, coin_reject, disp_req, chg_req, credit, busy
  );

  modport slave (
    input  coin_valid, coin_type, cancel, disp_ack, chg_ack,
    output coin_ready, coin_reject, disp_req, chg_req, credit, busy
  );
endinterface

// File: rtl/ven_dispense_ctrl.sv
// Vending dispense controller: collects nickels/dimes into a credit register, requests an
// item once credit reaches PRICE, then pays back any remainder one unit at a time.
// Cancel or an idle timeout in the collecting phase refunds the whole credit.
// Ports:
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   bus     : ven_dispense_ctrl_if.slave (coin, cancel, dispense and change handshakes)
module ven_dispense_ctrl #(
  parameter int unsigned PRICE      = 3,
  parameter int unsigned MAX_CREDIT = 7,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  ven_dispense_ctrl_if.slave   bus
);

  localparam logic [3:0] Price4   = 4'(PRICE);
  localparam logic [4:0] Price5   = 5'(PRICE);
  localparam logic [4:0] MaxCred5 = 5'(MAX_CREDIT);
  localparam logic [8:0] Timeout9 = 9'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StCollect, StDispense, StChange} state_e;

  state_e     r_state, w_state_d;
  logic [3:0] r_credit, w_credit_d;
  logic [7:0] r_timer, w_timer_d;
  logic       r_reject, w_reject_d;

  logic [1:0] w_coin_val;
  logic [4:0] w_sum;
  logic [8:0] w_timer_inc;
  logic       w_coin_ready;
  logic       w_accept;

  // Coin decode and acceptance
  always_comb begin
    w_coin_val = 2'd0;
    case (bus.coin_type)
      2'b01:   w_coin_val = 2'd1;
      2'b10:   w_coin_val = 2'd2;
      default: w_coin_val = 2'd0;
    endcase
  end

  assign w_sum        = {1'b0, r_credit} + {3'b000, w_coin_val};
  assign w_timer_inc  = {1'b0, r_timer} + 9'd1;
  assign w_coin_ready = (r_state == StIdle) || (r_state == StCollect);
  // Cancel wins over a coin offered in the same cycle.
  assign w_accept     = bus.coin_valid && w_coin_ready && (w_coin_val != 2'd0) &&
                        !bus.cancel && (w_sum <= MaxCred5);

  // State register and datapath registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= StIdle;
      r_credit <= 4'd0;
      r_timer  <= 8'd0;
      r_reject <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_credit <= w_credit_d;
      r_timer  <= w_timer_d;
      r_reject <= w_reject_d;
    end
  end

  // Next-state and next-datapath logic
  always_comb begin
    w_state_d  = r_state;
    w_credit_d = r_credit;
    w_timer_d  = 8'd0;
    // Every offered coin that is not credited produces a reject pulse, whatever the state.
    w_reject_d = bus.coin_valid && !w_accept;

    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_credit_d = w_sum[3:0];
          w_state_d  = (w_sum >= Price5) ? StDispense : StCollect;
        end
      end

      StCollect: begin
        if (bus.cancel) begin
          w_state_d = StChange;
        end else if (w_accept) begin
          w_credit_d = w_sum[3:0];
          if (w_sum >= Price5) begin
            w_state_d = StDispense;
          end
        end else begin
          w_timer_d = w_timer_inc[7:0];
          if (w_timer_inc >= Timeout9) begin
            w_state_d = StChange;
          end
        end
      end

      StDispense: begin
        if (bus.disp_ack) begin
          // Credit >= PRICE on entry; the guard keeps the register from wrapping regardless.
          if (r_credit > Price4) begin
            w_credit_d = r_credit - Price4;
            w_state_d  = StChange;
          end else begin
            w_credit_d = 4'd0;
            w_state_d  = StIdle;
          end
        end
      end

      StChange: begin
        if (r_credit == 4'd0) begin
          w_state_d = StIdle;
        end else if (bus.chg_ack) begin
          w_credit_d = r_credit - 4'd1;
          if (r_credit == 4'd1) begin
            w_state_d = StIdle;
          end
        end
      end

      default: begin
        w_state_d  = StIdle;
        w_credit_d = 4'd0;
      end
    endcase
  end

  // Outputs decoded from registered state only
  always_comb begin
    bus.coin_ready  = w_coin_ready;
    bus.busy        = (r_state == StDispense) || (r_state == StChange);
    bus.disp_req    = (r_state == StDispense);
    bus.chg_req     = (r_state == StChange) && (r_credit != 4'd0);
    bus.coin_reject = r_reject;
    bus.credit      = r_credit;
  end

endmodule

// File: tb/tb_ven_dispense_ctrl.sv
// Bench for ven_dispense_ctrl: directed scenarios plus randomized traffic against a
// behavioural model. Two instances: defaults, and PRICE=7/MAX_CREDIT=7/TIMEOUT=4.
module tb_ven_dispense_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ven_dispense_ctrl_if if0 ();
  ven_dispense_ctrl_if if1 ();

  ven_dispense_ctrl u_dut0 (.i_clk(clk), .i_rst_n(rst_n), .bus(if0));
  ven_dispense_ctrl #(.PRICE(7), .MAX_CREDIT(7), .TIMEOUT(4)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(if1)
  );

  int checks = 0;
  int failures = 0;

  // Model state: credit held, whether an item is being requested, whether a refund runs,
  // cycles spent collecting without an accepted coin, and the pending reject pulse.
  int m_credit;
  bit m_disp;
  bit m_ref;
  int m_cnt;
  bit m_rej;

  // {coin_ready, coin_reject, disp_req, chg_req, busy, credit[3:0]}
  function automatic logic [8:0] outs0();
    return {if0.coin_ready, if0.coin_reject, if0.disp_req, if0.chg_req, if0.busy, if0.credit};
  endfunction
  function automatic logic [8:0] outs1();
    return {if1.coin_ready, if1.coin_reject, if1.disp_req, if1.chg_req, if1.busy, if1.credit};
  endfunction

  task automatic drv0(input logic cv, input logic [1:0] ct, input logic can, input logic da,
                      input logic ca);
    if0.coin_valid = cv; if0.coin_type = ct; if0.cancel = can;
    if0.disp_ack = da; if0.chg_ack = ca;
  endtask
  task automatic drv1(input logic cv, input logic [1:0] ct, input logic can, input logic da,
                      input logic ca);
    if1.coin_valid = cv; if1.coin_type = ct; if1.cancel = can;
    if1.disp_ack = da; if1.chg_ack = ca;
  endtask

  // Inputs change on the falling edge; outputs are read on the falling edge after a rise.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (outs0() !== 9'b1_0_0_0_0_0000) begin
      failures++; $display("FAIL reset_outputs got=%b exp=%b", outs0(), 9'b1_0_0_0_0_0000);
    end
    checks++;
    if (outs1() !== 9'b1_0_0_0_0_0000) begin
      failures++; $display("FAIL reset_outputs_p7 got=%b exp=%b", outs1(), 9'b1_0_0_0_0_0000);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_exact_price();
    drv0(1, 2'b10, 0, 0, 0); step(); drv0(0, 0, 0, 0, 0);
    checks++;
    if (outs0() !== 9'b1_0_0_0_0_0010) begin
      failures++; $display("FAIL exact_dime got=%b exp=%b", outs0(), 9'b1_0_0_0_0_0010);
    end
    drv0(1, 2'b01, 0, 0, 0); step(); drv0(0, 0, 0, 0, 0);
    checks++;
    if (outs0() !== 9'b0_0_1_0_1_0011) begin
      failures++; $display("FAIL exact_dispense got=%b exp=%b", outs0(), 9'b0_0_1_0_1_0011);
    end
    step();
    checks++;
    if (outs0() !== 9'b0_0_1_0_1_0011) begin
      failures++; $display("FAIL exact_hold_req got=%b exp=%b", outs0(), 9'b0_0_1_0_1_0011);
    end
    drv0(0, 0, 0, 1, 0); step(); drv0(0, 0, 0, 0, 0);
    checks++;
    if (outs0() !== 9'b1_0_0_0_0_0000) begin
      failures++; $display("FAIL exact_done got=%b exp=%b", outs0(), 9'b1_0_0_0_0_0000);
    end
    step();
    checks++;
    if (outs0() !== 9'b1_0_0_0_0_0000) begin
      failures++; $display("FAIL exact_no_change got=%b exp=%b", outs0(), 9'b1_0_0_0_0_0000);
    end
  endtask

  task automatic test_change();
    drv0(1, 2'b10, 0, 0, 0); step();
    drv0(1, 2'b10, 0, 0, 0); step(); drv0(0, 0, 0, 0, 0);
    checks++;
    if (outs0() !== 9'b0_0_1_0_1_0100) begin
      failures++; $display("FAIL change_dispense got=%b exp=%b", outs0(), 9'b0_0_1_0_1_0100);
    end
    drv0(0, 0, 0, 1, 0); step(); drv0(0, 0, 0, 0, 0);
    checks++;
    if (outs0() !== 9'b0_0_0_1_1_0001) begin
      failures++; $display("FAIL change_req got=%b exp=%b", outs0(), 9'b0_0_0_1_1_0001);
    end
    drv0(0, 0, 0, 0, 1); step(); drv0(0, 0, 0, 0, 0);
    checks++;
    if (outs0() !== 9'b1_0_0_0_0_0000) begin
      failures++; $display("FAIL change_done got=%b exp=%b", outs0(), 9'b1_0_0_0_0_0000);
    end
  endtask

  task automatic test_cancel();
    drv0(1, 2'b01, 0, 0, 0); step(); drv0(0, 0, 0, 0, 0);
    checks++;
    if (outs0() !== 9'b1_0_0_0_0_0001) begin
      failures++; $display("FAIL cancel_nickel got=%b exp=%b", outs0(), 9'b1_0_0_0_0_0001);
    end
    drv0(1, 2'b10, 1, 0, 0); step(); drv0(0, 0, 0, 0, 0);
    checks++;
    if (outs0() !== 9'b0_1_0_1_1_0001) begin
      failures++; $display("FAIL cancel_reject got=%b exp=%b", outs0(), 9'b0_1_0_1_1_0001);
    end
    step();
    checks++;
    if (outs0() !== 9'b0_0_0_1_1_0001) begin
      failures++; $display("FAIL cancel_pulse_len got=%b exp=%b", outs0(), 9'b0_0_0_1_1_0001);
    end
    drv0(0, 0, 0, 1, 0); step(); drv0(0, 0, 0, 0, 0);
    checks++;
    if (outs0() !== 9'b0_0_0_1_1_0001) begin
      failures++; $display("FAIL cancel_dack_ignored got=%b exp=%b", outs0(), 9'b0_0_0_1_1_0001);
    end
    drv0(0, 0, 0, 0, 1); step(); drv0(0, 0, 0, 0, 0);
    checks++;
    if (outs0() !== 9'b1_0_0_0_0_0000) begin
      failures++; $display("FAIL cancel_done got=%b exp=%b", outs0(), 9'b1_0_0_0_0_0000);
    end
  endtask

  task automatic test_timeout();
    drv0(1, 2'b01, 0, 0, 0); step(); drv0(0, 0, 0, 0, 0);
    repeat (254) step();
    checks++;
    if (outs0() !== 9'b1_0_0_0_0_0001) begin
      failures++; $display("FAIL timeout_early got=%b exp=%b", outs0(), 9'b1_0_0_0_0_0001);
    end
    step();
    checks++;
    if (outs0() !== 9'b0_0_0_1_1_0001) begin
      failures++; $display("FAIL timeout_change got=%b exp=%b", outs0(), 9'b0_0_0_1_1_0001);
    end
    drv0(0, 0, 0, 0, 1); step(); drv0(0, 0, 0, 0, 0);
    checks++;
    if (outs0() !== 9'b1_0_0_0_0_0000) begin
      failures++; $display("FAIL timeout_done got=%b exp=%b", outs0(), 9'b1_0_0_0_0_0000);
    end
  endtask

  task automatic test_invalid_coin();
    drv0(0, 0, 0, 1, 1); step(); drv0(0, 0, 0, 0, 0);
    checks++;
    if (outs0() !== 9'b1_0_0_0_0_0000) begin
      failures++; $display("FAIL idle_acks_ignored got=%b exp=%b", outs0(), 9'b1_0_0_0_0_0000);
    end
    drv0(1, 2'b01, 0, 0, 0); step();
    drv0(1, 2'b11, 0, 0, 0); step(); drv0(0, 0, 0, 0, 0);
    checks++;
    if (outs0() !== 9'b1_1_0_0_0_0001) begin
      failures++; $display("FAIL invalid_11 got=%b exp=%b", outs0(), 9'b1_1_0_0_0_0001);
    end
    drv0(1, 2'b00, 0, 0, 0); step(); drv0(0, 0, 0, 0, 0);
    checks++;
    if (outs0() !== 9'b1_1_0_0_0_0001) begin
      failures++; $display("FAIL invalid_00 got=%b exp=%b", outs0(), 9'b1_1_0_0_0_0001);
    end
    drv0(0, 0, 1, 0, 0); step();
    drv0(0, 0, 0, 0, 1); step(); drv0(0, 0, 0, 0, 0);
    checks++;
    if (outs0() !== 9'b1_0_0_0_0_0000) begin
      failures++; $display("FAIL invalid_cleanup got=%b exp=%b", outs0(), 9'b1_0_0_0_0_0000);
    end
  endtask

  task automatic test_max_credit();
    for (int i = 1; i <= 3; i++) begin
      drv1(1, 2'b10, 0, 0, 0); step(); drv1(0, 0, 0, 0, 0);
      checks++;
      if (if1.credit !== 4'(2 * i)) begin
        failures++; $display("FAIL max_dime%0d got=%0d exp=%0d", i, if1.credit, 2 * i);
      end
    end
    drv1(1, 2'b10, 0, 0, 0); step(); drv1(0, 0, 0, 0, 0);
    checks++;
    if (outs1() !== 9'b1_1_0_0_0_0110) begin
      failures++; $display("FAIL max_overflow got=%b exp=%b", outs1(), 9'b1_1_0_0_0_0110);
    end
    drv1(1, 2'b01, 0, 0, 0); step(); drv1(0, 0, 0, 0, 0);
    checks++;
    if (outs1() !== 9'b0_0_1_0_1_0111) begin
      failures++; $display("FAIL max_dispense got=%b exp=%b", outs1(), 9'b0_0_1_0_1_0111);
    end
    drv1(0, 0, 0, 1, 0); step(); drv1(0, 0, 0, 0, 0);
    checks++;
    if (outs1() !== 9'b1_0_0_0_0_0000) begin
      failures++; $display("FAIL max_done got=%b exp=%b", outs1(), 9'b1_0_0_0_0_0000);
    end
  endtask

  task automatic test_async_reset();
    drv0(1, 2'b01, 0, 0, 0); step();
    drv0(1, 2'b01, 0, 0, 0); step();
    drv0(0, 0, 1, 0, 0); step(); drv0(0, 0, 0, 0, 0);
    checks++;
    if (outs0() !== 9'b0_0_0_1_1_0010) begin
      failures++; $display("FAIL areset_setup got=%b exp=%b", outs0(), 9'b0_0_0_1_1_0010);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (outs0() !== 9'b1_0_0_0_0_0000) begin
      failures++; $display("FAIL areset_immediate got=%b exp=%b", outs0(), 9'b1_0_0_0_0_0000);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drv0(1, 2'b01, 0, 0, 0); step(); drv0(0, 0, 0, 0, 0);
    checks++;
    if (outs0() !== 9'b1_0_0_0_0_0001) begin
      failures++; $display("FAIL areset_first_edge got=%b exp=%b", outs0(), 9'b1_0_0_0_0_0001);
    end
    drv0(0, 0, 1, 0, 0); step();
    drv0(0, 0, 0, 0, 1); step(); drv0(0, 0, 0, 0, 0);
  endtask

  // Applies one clock of the vending rules to the model, given this cycle's inputs.
  task automatic model_step(input bit cv, input int ct, input bit can, input bit da,
                            input bit ca, input int price, input int maxc, input int tout);
    int  val;
    bit  accept;
    val    = (ct == 1) ? 1 : (ct == 2) ? 2 : 0;
    accept = cv && !(m_disp || m_ref) && val != 0 && !can && (m_credit + val <= maxc);
    m_rej  = cv && !accept;
    if (m_disp) begin
      if (da) begin
        m_credit -= price;
        m_disp = 0;
        m_ref = (m_credit > 0);
      end
    end else if (m_ref) begin
      if (ca && m_credit > 0) begin
        m_credit--;
        if (m_credit == 0) m_ref = 0;
      end
    end else if (m_credit == 0) begin
      if (accept) begin
        m_credit = val;
        m_cnt = 0;
        if (m_credit >= price) m_disp = 1;
      end
    end else begin
      if (can) begin
        m_ref = 1;
      end else if (accept) begin
        m_credit += val;
        m_cnt = 0;
        if (m_credit >= price) m_disp = 1;
      end else begin
        m_cnt++;
        if (m_cnt >= tout) m_ref = 1;
      end
    end
  endtask

  task automatic test_random(input bit sel, input int n, input int price, input int maxc,
                             input int tout);
    logic [8:0] got, exp;
    bit cv, can, da, ca;
    int ct;
    rst_n = 1'b0;
    drv0(0, 0, 0, 0, 0); drv1(0, 0, 0, 0, 0);
    step();
    rst_n = 1'b1;
    m_credit = 0; m_disp = 0; m_ref = 0; m_cnt = 0; m_rej = 0;
    for (int i = 0; i < n; i++) begin
      cv  = ($urandom_range(0, 99) < 40);
      ct  = $urandom_range(0, 3);
      can = ($urandom_range(0, 99) < 8);
      da  = ($urandom_range(0, 99) < 30);
      ca  = ($urandom_range(0, 99) < 40);
      if (sel) drv1(cv, 2'(ct), can, da, ca);
      else     drv0(cv, 2'(ct), can, da, ca);
      model_step(cv, ct, can, da, ca, price, maxc, tout);
      step();
      got = sel ? outs1() : outs0();
      exp = {!(m_disp || m_ref), m_rej, m_disp, m_ref && (m_credit != 0), m_disp || m_ref,
             4'(m_credit)};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL rand%0d cyc=%0d got=%b exp=%b", sel, i, got, exp);
      end
      checks++;
      if (got[6] && got[5]) begin
        failures++;
        $display("FAIL rand%0d_req_overlap cyc=%0d got=%b exp=not both", sel, i, got[6:5]);
      end
    end
    drv0(0, 0, 0, 0, 0); drv1(0, 0, 0, 0, 0);
  endtask

  initial begin
    drv0(0, 0, 0, 0, 0);
    drv1(0, 0, 0, 0, 0);
    test_reset();
    test_exact_price();
    test_change();
    test_cancel();
    test_timeout();
    test_invalid_coin();
    test_max_credit();
    test_async_reset();
    test_random(1'b0, 2000, 3, 7, 255);
    test_random(1'b1, 2000, 7, 7, 4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
